// File: rtl/loop_issuer_if.sv
// Handshake bundle between a loop issuer and its command source / loop-body unit.
// The master side drives the descriptor, ready and acks; the slave side is the issuer.
interface loop_issuer_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] bound;
  logic [WIDTH-1:0] step;
  logic             iter_valid;
  logic             iter_ready;
  logic [WIDTH-1:0] iter_idx;
  logic             ack;
  logic             busy;
  logic             finish;
  logic [WIDTH-1:0] count;
  logic             err;

  modport master (
    output start, start_val, bound, step, iter_ready, ack,
    input  iter_valid, iter_idx, busy, finish, count, err
  );

  modport slave (
    input  start, start_val, bound, step, iter_ready, ack,
    output iter_valid, iter_idx, busy, finish, count, err
  );
endinterface

// File: rtl/loop_issuer.sv
// Issues loop iteration indices over valid/ready, limits unacked iterations to MAX_OUT,
// and raises finish once every issued iteration has been acknowledged.
module loop_issuer #(
  parameter int WIDTH   = 8,
  parameter int MAX_OUT = 4
) (
  input logic         clk,
  input logic         rst,
  loop_issuer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [3:0] MAX_OUT_L = 4'(MAX_OUT);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] idx, bound_q, step_q, count_q;
  logic [3:0]       outst, outst_nxt;
  logic             err_q;
  logic             valid, busy, finish;
  logic             xfer, ack_ok, start_ok, last;
  logic [WIDTH:0]   next_sum;

  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    busy      = 1'b0;
    finish    = 1'b0;
    valid     = (state == ISSUE) && (outst < MAX_OUT_L);
    xfer      = valid && bus.iter_ready;
    ack_ok    = bus.ack && (outst != 4'd0);
    // Extra bit catches index wrap-around past the top of the WIDTH range.
    next_sum  = {1'b0, idx} + {1'b0, step_q};
    last      = next_sum[WIDTH] || (next_sum[WIDTH-1:0] >= bound_q);

    unique case ({xfer, ack_ok})
      2'b10:   outst_nxt = outst + 4'd1;
      2'b01:   outst_nxt = outst - 4'd1;
      default: outst_nxt = outst;
    endcase

    unique case (state)
      IDLE, DONE: begin
        finish = (state == DONE);
        if (bus.start) begin
          start_ok  = 1'b1;
          state_nxt = (bus.start_val >= bus.bound) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        busy = 1'b1;
        if (xfer && last) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (outst_nxt == 4'd0) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      outst   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      outst <= outst_nxt;
      if (start_ok) begin
        count_q <= '0;
        err_q   <= 1'b0;
        if (bus.start_val < bus.bound) idx <= bus.start_val;
      end else begin
        if (xfer && !last) idx <= next_sum[WIDTH-1:0];
        if (ack_ok && (count_q != '1)) count_q <= count_q + WIDTH'(1);
        if (bus.ack && (outst == 4'd0)) err_q <= 1'b1;
      end
    end
  end

  // Descriptor holding registers carry no reset; they are only read after a start.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      bound_q <= bus.bound;
      step_q  <= (bus.step == '0) ? WIDTH'(1) : bus.step;
    end
  end

  assign bus.iter_valid = valid;
  assign bus.iter_idx   = idx;
  assign bus.busy       = busy;
  assign bus.finish     = finish;
  assign bus.count      = count_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_loop_issuer.sv
// Bench for loop_issuer: descriptor table, hand-written corner sequences and
// randomized loops checked against an index-list reference model.
module tb_loop_issuer;
  localparam int WIDTH   = 8;
  localparam int MAX_OUT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  loop_issuer_if #(.WIDTH(WIDTH)) bus ();
  loop_issuer #(.WIDTH(WIDTH), .MAX_OUT(MAX_OUT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int sv, b, st, n, first, last;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.iter_ready = 1'b0; bus.ack = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start(input int sv, input int b, input int st);
    bus.start     = 1'b1;
    bus.start_val = WIDTH'(sv);
    bus.bound     = WIDTH'(b);
    bus.step      = WIDTH'(st);
    tick();
    bus.start = 1'b0;
  endtask

  // Reference: the iteration list is plain integer arithmetic over the descriptor.
  task automatic run_desc(input int sv, input int b, input int st, input bit rnd,
                          input string tag, output int n_got, output int first,
                          output int last);
    int  exp_q[$];
    int  got_q[$];
    int  due[$];
    int  model_out;
    int  last_ack_edge;
    int  start_edge;
    int  s;
    bit  done;
    bit  win_bad;
    model_out = 0; last_ack_edge = -1; done = 0; win_bad = 0;
    s = (st % 256 == 0) ? 1 : st;
    for (int i = sv; i < b; i += s) exp_q.push_back(i);

    pulse_start(sv, b, st);
    start_edge = cyc;
    chk({tag, " finish_clr"}, bus.finish, 0);
    chk({tag, " count_clr"}, bus.count, 0);
    chk({tag, " err_clr"}, bus.err, 0);

    for (int k = 0; k < 4000 && !done; k++) begin
      bit rdy, ak, x;
      rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rnd) ak = (model_out > 0) && ($urandom_range(0, 1) == 1);
      else begin
        ak = (due.size() > 0) && (due[0] == cyc);
        if (ak) void'(due.pop_front());
      end
      bus.iter_ready = rdy;
      bus.ack        = ak;
      x = bus.iter_valid && rdy;
      if (bus.iter_valid && model_out >= MAX_OUT) win_bad = 1;
      if (x) begin
        got_q.push_back(int'(bus.iter_idx));
        if (!rnd) due.push_back(cyc + 2);
      end
      if (ak) last_ack_edge = cyc + 1;
      model_out += int'(x) - int'(ak);
      tick();
      if (bus.finish) done = 1;
    end
    bus.iter_ready = 1'b0;
    bus.ack        = 1'b0;

    chk({tag, " finish_seen"}, done, 1);
    chk({tag, " n_issued"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s idx%0d", tag, i), (i < got_q.size()) ? got_q[i] : -1, exp_q[i]);
    chk({tag, " window"}, win_bad, 0);
    chk({tag, " count"}, bus.count, exp_q.size());
    chk({tag, " err"}, bus.err, 0);
    chk({tag, " busy"}, bus.busy, 0);
    if (exp_q.size() > 0) chk({tag, " finish_time"}, cyc, last_ack_edge);
    else                  chk({tag, " finish_time"}, cyc, start_edge + 1);
    n_got = got_q.size();
    first = (got_q.size() > 0) ? got_q[0] : -1;
    last  = (got_q.size() > 0) ? got_q[got_q.size()-1] : -1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, f, l, xf;
    tbl[0] = '{0,   3,   1, 3, 0,   2};
    tbl[1] = '{5,   5,   1, 0, 0,   0};
    tbl[2] = '{0,   2,   0, 2, 0,   1};
    tbl[3] = '{250, 255, 4, 2, 250, 254};
    tbl[4] = '{10,  20,  3, 4, 10,  19};
    tbl[5] = '{7,   3,   1, 0, 0,   0};
    tbl[6] = '{0,   255, 64, 4, 0,  192};
    tbl[7] = '{254, 255, 1, 1, 254, 254};

    bus.start_val = '0; bus.bound = '0; bus.step = '0;
    rst = 1'b1;
    bus.start = 1'b0; bus.iter_ready = 1'b0; bus.ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst iter_valid", bus.iter_valid, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst finish", bus.finish, 0);
    chk("rst err", bus.err, 0);
    chk("rst iter_idx", bus.iter_idx, 0);
    chk("rst count", bus.count, 0);

    // Spurious ack in IDLE
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    chk("idle_ack err", bus.err, 1);
    chk("idle_ack count", bus.count, 0);

    foreach (tbl[i]) begin
      run_desc(tbl[i].sv, tbl[i].b, tbl[i].st, 1'b0, $sformatf("tbl%0d", i), n, f, l);
      chk($sformatf("tbl%0d n", i), n, tbl[i].n);
      if (tbl[i].n > 0) begin
        chk($sformatf("tbl%0d first", i), f, tbl[i].first);
        chk($sformatf("tbl%0d last", i), l, tbl[i].last);
      end
    end

    // Backpressure: index held while not ready
    do_reset();
    pulse_start(0, 10, 1);
    for (int i = 0; i < 3; i++) begin
      chk("bp valid", bus.iter_valid, 1);
      chk("bp idx", bus.iter_idx, 0);
      tick();
    end
    bus.iter_ready = 1'b1; tick(); bus.iter_ready = 1'b0;
    chk("bp advance", bus.iter_idx, 1);

    // Window fill, single ack reopening, ignored start, async reset
    do_reset();
    pulse_start(0, 100, 1);
    bus.iter_ready = 1'b1;
    xf = 0;
    for (int i = 0; i < 7; i++) begin xf += int'(bus.iter_valid); tick(); end
    chk("win xfers", xf, 4);
    chk("win valid_low", bus.iter_valid, 0);
    bus.ack = 1'b1; xf += int'(bus.iter_valid); tick(); bus.ack = 1'b0;
    for (int i = 0; i < 4; i++) begin xf += int'(bus.iter_valid); tick(); end
    chk("win one_more", xf, 5);
    chk("win count", bus.count, 1);
    bus.iter_ready = 1'b0;
    bus.start = 1'b1; bus.start_val = 8'd50; bus.bound = 8'd60; bus.step = 8'd3;
    tick();
    bus.start = 1'b0;
    chk("ign_start idx", bus.iter_idx, 5);
    chk("ign_start busy", bus.busy, 1);
    chk("ign_start count", bus.count, 1);
    bus.ack = 1'b1; tick(); tick(); bus.ack = 1'b0;
    chk("pre_rst valid", bus.iter_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst iter_valid", bus.iter_valid, 0);
    chk("arst busy", bus.busy, 0);
    chk("arst finish", bus.finish, 0);
    chk("arst err", bus.err, 0);
    chk("arst iter_idx", bus.iter_idx, 0);
    chk("arst count", bus.count, 0);
    tick();
    rst = 1'b0;
    bus.ack = 1'b1; tick(); tick(); bus.ack = 1'b0;
    chk("post_rst err", bus.err, 1);
    chk("post_rst count", bus.count, 0);
    run_desc(3, 9, 2, 1'b0, "after_rst", n, f, l);

    // Transfer and ack on the same edge keep outstanding constant
    do_reset();
    pulse_start(0, 100, 1);
    bus.iter_ready = 1'b1;
    xf = 0;
    for (int i = 0; i < 3; i++) begin xf += int'(bus.iter_valid); tick(); end
    bus.ack = 1'b1; xf += int'(bus.iter_valid); tick(); bus.ack = 1'b0;
    for (int i = 0; i < 3; i++) begin xf += int'(bus.iter_valid); tick(); end
    chk("simul xfers", xf, 5);
    chk("simul valid_low", bus.iter_valid, 0);
    chk("simul count", bus.count, 1);

    do_reset();
    for (int r = 0; r < 25; r++) begin
      int sv, b, st;
      sv = int'($urandom_range(0, 255));
      b  = int'($urandom_range(0, 255));
      st = int'($urandom_range(0, 12));
      run_desc(sv, b, st, 1'b1, $sformatf("rnd%0d", r), n, f, l);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/loop_issuer.md
# loop_issuer

Command-side counterpart of the loop engine. The engine runs a bounded counter and raises `finish`; this block runs the loop from the issuing side. It accepts a loop descriptor (start value, bound, step) and issues iteration indices to a loop-body unit over a valid/ready handshake. It tracks per-iteration completion acks with a bounded outstanding window and raises `finish` once every issued iteration has been acknowledged.

## Interface
- `WIDTH`, default 8: width of the index, bound, step and count.
- `MAX_OUT`, default 4: maximum number of issued but unacked iterations (1..15).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `start`  in  1  one-cycle request to begin a loop. Accepted only in IDLE or DONE.
- `start_val`  in  WIDTH  first index; sampled when `start` is accepted.
- `bound`  in  WIDTH  exclusive upper bound; sampled when `start` is accepted.
- `step`  in  WIDTH  index increment; sampled when `start` is accepted. A value of 0 is treated as 1.
- `iter_valid`  out  1  an iteration index is offered.
- `iter_ready`  in  1  the body accepts the offered index.
- `iter_idx`  out  WIDTH  the index offered.
- `ack`  in  1  one-cycle completion pulse from the body, one per accepted index.
- `busy`  out  1  high in ISSUE and DRAIN.
- `finish`  out  1  high in DONE; held until the next accepted `start` or reset.
- `count`  out  WIDTH  number of acks received in the current loop.
- `err`  out  1  sticky; set by an ack that arrives while outstanding = 0. Cleared by `start` or reset.

## Operation
States: IDLE, ISSUE, DRAIN, DONE.

Transitions:
- IDLE/DONE + `start`: latch the descriptor, clear `count`/`err`/`finish`.
  - If `start_val` ≥ `bound`, go to DRAIN (zero-trip loop).
  - Otherwise load `iter_idx` = `start_val` and go to ISSUE.
- ISSUE: `iter_valid` = (outstanding < MAX_OUT). A transfer occurs on a rising edge with `iter_valid` && `iter_ready`.
  - On transfer, compute next = `iter_idx` + step with a WIDTH+1 bit sum.
  - If the carry is set or next ≥ `bound`, go to DRAIN. Otherwise `iter_idx` ← next and stay in ISSUE.
- DRAIN: `iter_valid` = 0. Go to DONE on the edge where the next outstanding count is 0.
- DONE: `finish` = 1, `busy` = 0.
- `start` in ISSUE or DRAIN is ignored; the descriptor inputs are not sampled.

Outstanding counter:
- +1 on each transfer, −1 on each ack.
- A transfer and an ack on the same edge leave it unchanged.
- An ack with outstanding = 0 is ignored for counting and sets `err`.
- `count` increments on each valid ack and saturates at all-ones.

Reset values (asynchronous; any state, including mid-loop):
- State = IDLE.
- `iter_valid`, `busy`, `finish`, `err` = 0.
- `iter_idx`, `count`, outstanding = 0.
- Iterations in flight are abandoned, and acks after reset are treated as spurious.

## Timing
- `start` sampled at edge E0 → ISSUE from E0, with `iter_valid` high in the cycle after E0 when MAX_OUT > 0.
- `iter_idx` is registered. It is stable while `iter_valid` && !`iter_ready`, and advances on the transfer edge.
- Throughput is one index per cycle while `iter_ready` = 1 and the window is not full.
- When the last outstanding ack arrives at edge E, `finish` is high in the cycle after E.
  - This also holds when that ack coincides with the final transfer leaving ISSUE: the transfer counts, so outstanding ≥ 1 and DRAIN waits.
- Zero-trip loop: `start` at E0 → DRAIN after E0 → DONE at E0+1 → `finish` high after E0+1. No `iter_valid` is issued.
- `count` and `err` update on the same edge as the ack they reflect.

## Test plan
- Basic loop: `start_val` = 0, `bound` = 3, `step` = 1, `iter_ready` = 1, ack 2 cycles after each transfer → indices 0, 1, 2 issued back-to-back; `finish` high after the third ack; `count` = 3; `err` = 0.
- Zero-trip and zero step:
  - `start_val` = 5, `bound` = 5 → no `iter_valid`; `finish` high two edges after `start`; `count` = 0.
  - `step` = 0, `bound` = 2 → indices 0, 1.
- Backpressure and window:
  - Hold `iter_ready` low for 3 cycles → `iter_idx` stays stable at 0.
  - Withhold acks with MAX_OUT = 4 → exactly 4 transfers, then `iter_valid` drops; one ack → exactly one more transfer.
- Wrap/overflow: WIDTH = 8, `start_val` = 250, `bound` = 255, `step` = 4 → indices 250 and 254 only (258 carries out); `finish` after 2 acks.
- Simultaneous events and error:
  - A transfer and an ack on the same edge keep outstanding constant.
  - An ack in IDLE sets `err` = 1 and leaves `count` = 0; a following `start` clears `err`.
  - `start` pulsed during ISSUE is ignored.
- Reset mid-loop: assert `rst` asynchronously between edges during ISSUE with 2 outstanding → all outputs 0 immediately. After release, two acks set `err` and leave `count` = 0; a new loop then runs normally.
